fc_argmax: RTL and testbench
============================

# fc_argmax

Classification stage downstream of the fully-connected output layer's result FIFO. It pops LAYER_HEIGHT signed scores per frame from the FIFO read port and tracks the running maximum. It then presents the index of the winning class, and optionally its score, on a valid/ready output. It is the last compute block before the classifier result leaves the CNN datapath.

## Interface
- WORD_SIZE, 16: width of one signed two's-complement score word
- LAYER_HEIGHT, 4: scores per frame, must be ≥ 2; IDX_W = $clog2(LAYER_HEIGHT)
- clk_i  input  1  single clock; all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- empty_i  input  1  FIFO empty flag
- data_i  input  WORD_SIZE  FIFO read data; valid the cycle after an accepted read
- ren_o  output  1  FIFO read enable; asserted only when empty_i is low
- valid_o  output  1  result valid
- ready_i  input  1  downstream ready
- data_o  output  IDX_W  winning class index
- score_o  output  WORD_SIZE  winning score; present only with FC_ARGMAX_SCORE_OUT_EN

## Operation
- States:
  - S_READ: issue reads and consume data.
  - S_OUT: result held.
- Counters:
  - rd_cnt counts accepted reads, 0..LAYER_HEIGHT.
  - rx_cnt counts received words, 0..LAYER_HEIGHT-1.
- Read issue: ren_o = (state==S_READ) && !empty_i && (rd_cnt < LAYER_HEIGHT). An accepted read (ren_o high) sets rd_pend for one cycle.
- Capture on rd_pend:
  - If rx_cnt==0, load best_val=data_i and best_idx=0.
  - Otherwise, if $signed(data_i) > $signed(best_val), load best_val=data_i and best_idx=rx_cnt.
  - Increment rx_cnt in both cases.
- Ties keep the lowest index: the compare is strict greater-than.
- Frame end: the capture with rx_cnt==LAYER_HEIGHT-1 moves to S_OUT and registers data_o=best result, including that final word.
- S_OUT:
  - valid_o=1 and ren_o=0.
  - data_o and score_o are stable until the handshake.
- Handshake: valid_o && ready_i returns to S_READ. The handshake clears rd_cnt and rx_cnt, and valid_o drops the next cycle.
- FIFO empty mid-frame: ren_o deasserts. Counters and best_val hold. Reads resume when empty_i falls, with no word lost or duplicated.
- Reset (any state, including mid-frame):
  - state=S_READ; all counters, rd_pend and best values are zero.
  - ren_o=0, valid_o=0, data_o=0, score_o=0.
  - Partial frame results are discarded. Words already popped are not re-read.

## Timing
- The FIFO has a 1-cycle read latency: a read accepted in cycle N presents data_i in cycle N+1.
- Back-to-back reads are allowed every cycle while the FIFO is non-empty.
- Minimum frame latency: LAYER_HEIGHT+1 cycles from the first ren_o to valid_o.
  - Last read is in cycle LAYER_HEIGHT-1 (0-based).
  - Last capture is in cycle LAYER_HEIGHT.
  - valid_o is high in cycle LAYER_HEIGHT+1.
- Back-to-back frames: ren_o may reassert in the cycle after the handshake. The minimum gap from valid_o falling to the next ren_o is 0 cycles.
- Frame period with ready_i tied high and the FIFO never empty: LAYER_HEIGHT+2 cycles.
- ren_o is combinational from state, rd_cnt and empty_i. All other outputs are registered.

## Configuration
- FC_ARGMAX_SCORE_OUT_EN:
  - Defined: the score_o port exists and carries best_val, registered alongside data_o.
  - Undefined: score_o and its output register are removed. Internal best_val is still kept for the compare. Index behaviour and timing are identical.

## Test plan
- Basic frame: LAYER_HEIGHT=4, FIFO words 0x0136, 0x0514, 0x0010, 0x00af, ready_i=1 -> valid_o one cycle, data_o=1, score_o=0x0514, latency 5 cycles from the first ren_o.
- Signed compare: 0xFFF0, 0xFF00, 0x8000, 0xFFFF -> data_o=3, score_o=0xFFFF. With 0x7FFF, 0x8000, 0, 1 -> data_o=0.
- Ties: 5, 5, 3, 5 -> data_o=0. With 3, 7, 7, 1 -> data_o=1.
- Backpressure and starvation:
  - Hold empty_i high for 3 cycles after word 2, with ready_i=0 for 4 cycles after valid_o.
  - Required: ren_o stays low while empty or in S_OUT, exactly 4 reads per frame, and outputs stay stable until ready_i.
- Back-to-back frames: 3 frames queued in the FIFO, ready_i=1 -> results every 6 cycles, with correct indices per frame.
- Mid-frame reset:
  - Assert reset_i after 2 reads, then release.
  - Required: all outputs 0 in the cycle after reset.
  - The next 4 FIFO words form a fresh frame with the correct argmax.

Source files
------------

// File: rtl/fc_argmax_if.sv
// fc_argmax_if: FIFO read port plus valid/ready result port of the argmax stage.
// The winning-score wire exists only when FC_ARGMAX_SCORE_OUT_EN is defined.
interface fc_argmax_if #(
  parameter int WORD_SIZE    = 16,
  parameter int LAYER_HEIGHT = 4
);
  localparam int IDX_W = $clog2(LAYER_HEIGHT);

  logic                 empty_i;
  logic [WORD_SIZE-1:0] data_i;
  logic                 ren_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [IDX_W-1:0]     data_o;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic [WORD_SIZE-1:0] score_o;

  modport master (
    input  empty_i, data_i, ready_i,
    output ren_o, valid_o, data_o, score_o
  );

  modport slave (
    output empty_i, data_i, ready_i,
    input  ren_o, valid_o, data_o, score_o
  );
`else
  modport master (
    input  empty_i, data_i, ready_i,
    output ren_o, valid_o, data_o
  );

  modport slave (
    output empty_i, data_i, ready_i,
    input  ren_o, valid_o, data_o
  );
`endif
endinterface

// File: rtl/fc_argmax.sv
// fc_argmax: pops LAYER_HEIGHT signed scores per frame from the result FIFO,
// tracks the running maximum (lowest index wins a tie) and presents the
// winning class index on a valid/ready port.
// Optional feature macro FC_ARGMAX_SCORE_OUT_EN: also registers and outputs
// the winning score. Without it the score is kept internally for the compare.
module fc_argmax #(
  parameter int WORD_SIZE    = 16,
  parameter int LAYER_HEIGHT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  fc_argmax_if.master bus
);
  localparam int IDX_W = $clog2(LAYER_HEIGHT);
  localparam int CNT_W = $clog2(LAYER_HEIGHT + 1);
  localparam logic [CNT_W-1:0] RD_FULL = CNT_W'(LAYER_HEIGHT);
  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(LAYER_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1'b1);

  typedef enum logic [0:0] {
    S_READ = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [CNT_W-1:0]     rd_cnt_r;
  logic [IDX_W-1:0]     rx_cnt_r;
  logic                 rd_pend_r;
  logic [WORD_SIZE-1:0] best_val_r;
  logic [IDX_W-1:0]     best_idx_r;
  logic                 valid_r;
  logic [IDX_W-1:0]     data_r;

  logic                 ren_s;
  logic                 hs_s;
  logic                 last_cap_s;
  logic                 take_s;
  logic [WORD_SIZE-1:0] cand_val_s;
  logic [IDX_W-1:0]     cand_idx_s;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_READ;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state, read issue, frame-end and handshake decode.
  // Reads are held off while reset is asserted so no word is popped and lost.
  always_comb begin
    next_state_s = state_r;
    ren_s        = 1'b0;
    hs_s         = 1'b0;
    last_cap_s   = 1'b0;
    case (state_r)
      S_READ: begin
        if (!reset_i && !bus.empty_i && (rd_cnt_r < RD_FULL)) begin
          ren_s = 1'b1;
        end else begin
          ren_s = 1'b0;
        end
        if (rd_pend_r && (rx_cnt_r == RX_LAST)) begin
          last_cap_s   = 1'b1;
          next_state_s = S_OUT;
        end else begin
          next_state_s = S_READ;
        end
      end
      S_OUT: begin
        if (valid_r && bus.ready_i) begin
          hs_s         = 1'b1;
          next_state_s = S_READ;
        end else begin
          next_state_s = S_OUT;
        end
      end
      default: begin
        next_state_s = S_READ;
      end
    endcase
  end

  // Running-max candidate: first word of a frame always loads, later words
  // replace the best only when strictly greater so ties keep the lowest index
  always_comb begin
    take_s     = 1'b0;
    cand_val_s = best_val_r;
    cand_idx_s = best_idx_r;
    if (rx_cnt_r == {IDX_W{1'b0}}) begin
      take_s = 1'b1;
    end else if ($signed(bus.data_i) > $signed(best_val_r)) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    if (take_s) begin
      cand_val_s = bus.data_i;
      cand_idx_s = rx_cnt_r;
    end else begin
      cand_val_s = best_val_r;
      cand_idx_s = best_idx_r;
    end
  end

  // Read/receive counters, capture pipeline and the registered result
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_cnt_r   <= {CNT_W{1'b0}};
      rx_cnt_r   <= {IDX_W{1'b0}};
      rd_pend_r  <= 1'b0;
      best_val_r <= {WORD_SIZE{1'b0}};
      best_idx_r <= {IDX_W{1'b0}};
      valid_r    <= 1'b0;
      data_r     <= {IDX_W{1'b0}};
    end else begin
      rd_pend_r <= ren_s;
      if (hs_s) begin
        rd_cnt_r <= {CNT_W{1'b0}};
        rx_cnt_r <= {IDX_W{1'b0}};
        valid_r  <= 1'b0;
      end else begin
        if (ren_s) begin
          rd_cnt_r <= rd_cnt_r + CNT_ONE;
        end
        if (rd_pend_r) begin
          best_val_r <= cand_val_s;
          best_idx_r <= cand_idx_s;
          if (last_cap_s) begin
            rx_cnt_r <= {IDX_W{1'b0}};
          end else begin
            rx_cnt_r <= rx_cnt_r + IDX_ONE;
          end
        end
        if (last_cap_s) begin
          valid_r <= 1'b1;
          data_r  <= cand_idx_s;
        end
      end
    end
  end

  assign bus.ren_o   = ren_s;
  assign bus.valid_o = valid_r;
  assign bus.data_o  = data_r;

`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic [WORD_SIZE-1:0] score_r;

  // Winning score, loaded together with the index at frame end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_r <= {WORD_SIZE{1'b0}};
    end else if (last_cap_s) begin
      score_r <= cand_val_s;
    end else begin
      score_r <= score_r;
    end
  end

  assign bus.score_o = score_r;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: randomized self-checking bench for fc_argmax. A queue-based
// FIFO feeds the DUT; a frame-level model groups popped words into frames and
// computes the expected argmax with a plain loop. Honors FC_ARGMAX_SCORE_OUT_EN.
module tb_fc_argmax;
  localparam int WS = 16;
  localparam int LH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Free-running clock
  always #5 clk = ~clk;

  fc_argmax_if #(.WORD_SIZE(WS), .LAYER_HEIGHT(LH)) bus ();

  fc_argmax #(.WORD_SIZE(WS), .LAYER_HEIGHT(LH)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [WS-1:0] fifo_q[$];
  logic [WS-1:0] cur_fr[$];
  int            exp_idx_q[$];
  logic [WS-1:0] exp_val_q[$];

  int cyc = 0;
  int pops_fr = 0;
  int hs_cnt = 0;
  int first_ren_cyc = 0;
  int last_hs_cyc = -1;
  bit starve = 1'b0;
  bit rand_ready = 1'b0;
  bit rand_starve = 1'b0;
  bit lat_chk = 1'b0;
  bit per_chk = 1'b0;
  bit hold_pend = 1'b0;
  bit drop_pend = 1'b0;
  bit prev_valid = 1'b0;
  logic [31:0] hold_idx = 32'd0;
  logic [31:0] hold_score = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: every popped word joins the current frame; a full frame yields
  // the index of its largest signed value, earliest index on a tie.
  task automatic model_pop(input logic [WS-1:0] w);
    int best;
    cur_fr.push_back(w);
    if (cur_fr.size() == LH) begin
      best = 0;
      for (int i = 1; i < LH; i++) begin
        if ($signed(cur_fr[i]) > $signed(cur_fr[best])) best = i;
      end
      exp_idx_q.push_back(best);
      exp_val_q.push_back(cur_fr[best]);
      cur_fr.delete();
    end
  endtask

  task automatic update_empty();
    bus.empty_i = starve || (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [WS-1:0] w);
    fifo_q.push_back(w);
    update_empty();
  endtask

  task automatic set_starve(input bit v);
    starve = v;
    update_empty();
  endtask

  // One clock: observe at negedge, then drive FIFO data/flags after posedge
  task automatic cycle();
    logic [WS-1:0] w;
    bit popped;
    w = '0;
    popped = 1'b0;
    @(negedge clk);
    if (bus.empty_i || bus.valid_o || reset) check_eq("ren_gate", bus.ren_o, 0);
    if (drop_pend) check_eq("valid_drop", bus.valid_o, 0);
    drop_pend = 1'b0;
    if (hold_pend) begin
      check_eq("hold_valid", bus.valid_o, 1);
      check_eq("hold_idx", bus.data_o, hold_idx);
`ifdef FC_ARGMAX_SCORE_OUT_EN
      check_eq("hold_score", bus.score_o, hold_score);
`endif
    end
    if (bus.valid_o && !prev_valid && lat_chk) check_eq("latency", cyc - first_ren_cyc, LH + 1);
    if (bus.ren_o && fifo_q.size() > 0) begin
      if (pops_fr == 0) first_ren_cyc = cyc;
      w = fifo_q.pop_front();
      popped = 1'b1;
      pops_fr++;
      model_pop(w);
    end
    if (bus.valid_o && bus.ready_i && !reset) begin
      if (exp_idx_q.size() > 0) begin
        check_eq("idx", bus.data_o, exp_idx_q.pop_front());
`ifdef FC_ARGMAX_SCORE_OUT_EN
        check_eq("score", bus.score_o, exp_val_q.pop_front());
`else
        void'(exp_val_q.pop_front());
`endif
      end else begin
        check_eq("result_expected", bus.valid_o, 0);
      end
      check_eq("reads_per_frame", pops_fr, LH);
      if (per_chk && last_hs_cyc >= 0) check_eq("frame_period", cyc - last_hs_cyc, LH + 2);
      last_hs_cyc = cyc;
      hs_cnt++;
      pops_fr = 0;
      drop_pend = 1'b1;
    end
    hold_pend = bus.valid_o && !bus.ready_i && !reset;
    hold_idx = 32'(bus.data_o);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    hold_score = 32'(bus.score_o);
`endif
    prev_valid = bus.valid_o;
    @(posedge clk);
    #1;
    cyc++;
    bus.data_i = popped ? w : WS'($urandom);
    if (rand_ready) bus.ready_i = 1'($urandom_range(0, 1));
    if (rand_starve) starve = ($urandom_range(0, 3) == 0);
    update_empty();
  endtask

  task automatic clear_model();
    cur_fr.delete();
    exp_idx_q.delete();
    exp_val_q.delete();
    pops_fr = 0;
    hold_pend = 1'b0;
    drop_pend = 1'b0;
    prev_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_model();
    repeat (n) cycle();
    reset = 1'b0;
    clear_model();
    check_eq("rst_valid", bus.valid_o, 0);
    check_eq("rst_idx", bus.data_o, 0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    check_eq("rst_score", bus.score_o, 0);
`endif
  endtask

  task automatic run_frames(input int n, input int budget);
    int target;
    int k;
    target = hs_cnt + n;
    k = 0;
    while (hs_cnt < target && k < budget) begin
      cycle();
      k++;
    end
    check_eq("frame_done", 32'(hs_cnt >= target), 1);
  endtask

  task automatic push4(input logic [WS-1:0] a, input logic [WS-1:0] b,
                       input logic [WS-1:0] c, input logic [WS-1:0] d);
    push(a); push(b); push(c); push(d);
  endtask

  initial begin
    int k;
    logic [WS-1:0] w;
    bus.empty_i = 1'b1;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;

    // Reset with a frame already waiting: no read may leak out during reset
    push4(16'h0136, 16'h0514, 16'h0010, 16'h00af);
    do_reset(3);

    // Directed frames with ready high and a full FIFO
    bus.ready_i = 1'b1;
    lat_chk = 1'b1;
    run_frames(1, 30);
    push4(16'hFFF0, 16'hFF00, 16'h8000, 16'hFFFF);
    run_frames(1, 30);
    push4(16'h7FFF, 16'h8000, 16'h0000, 16'h0001);
    run_frames(1, 30);
    push4(16'h0005, 16'h0005, 16'h0003, 16'h0005);
    run_frames(1, 30);
    push4(16'h0003, 16'h0007, 16'h0007, 16'h0001);
    run_frames(1, 30);

    // Starvation after two words, then backpressure for four valid cycles
    lat_chk = 1'b0;
    bus.ready_i = 1'b0;
    push4(WS'($urandom), WS'($urandom), WS'($urandom), WS'($urandom));
    k = 0;
    while (pops_fr < 2 && k < 20) begin cycle(); k++; end
    set_starve(1'b1);
    repeat (3) cycle();
    set_starve(1'b0);
    k = 0;
    while (!prev_valid && k < 20) begin cycle(); k++; end
    check_eq("bp_valid_seen", 32'(prev_valid), 1);
    repeat (3) cycle();
    bus.ready_i = 1'b1;
    run_frames(1, 10);

    // Three frames queued back to back
    lat_chk = 1'b1;
    per_chk = 1'b1;
    last_hs_cyc = -1;
    for (int i = 0; i < 3 * LH; i++) push(WS'($urandom));
    run_frames(3, 40);
    per_chk = 1'b0;

    // Reset after two reads; the following four words form a fresh frame
    for (int i = 0; i < 6; i++) push(WS'($urandom));
    k = 0;
    while (pops_fr < 2 && k < 20) begin cycle(); k++; end
    do_reset(1);
    run_frames(1, 30);

    // Random frames with random backpressure and starvation, many ties
    lat_chk = 1'b0;
    rand_ready = 1'b1;
    rand_starve = 1'b1;
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < LH; i++) begin
        if (f % 2 == 0) w = WS'($urandom);
        else w = WS'($urandom_range(0, 6)) - 16'd3;
        push(w);
      end
      run_frames(1, 300);
    end
    rand_ready = 1'b0;
    rand_starve = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
